rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: reads RX FIFO bytes over APB, frames SFD/PHR/payload
// and streams payload bytes to a valid/ready sink.
// Ports: clk, reset (async, high), enable run request;
//   APB master psel/penable/pwrite, FIFO pready/pslverr/prdata;
//   stream m_data/m_valid/m_last out, m_ready in;
//   status frame_len, frame_done pulse, err_len pulse.

module rx_frame_ctrl #(
    parameter logic [7:0] SFD     = 8'hA7,
    parameter int         MAX_LEN = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    input  logic       pready,
    input  logic       pslverr,
    input  logic [7:0] prdata,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic [6:0] frame_len,
    output logic       frame_done,
    output logic       err_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_EMIT
    } state_t;

    typedef enum logic [1:0] {
        PH_HUNT,
        PH_LEN,
        PH_PAY
    } phase_t;

    localparam logic [7:0] MAX8 = 8'(MAX_LEN);

    state_t     state;
    state_t     state_nx;
    phase_t     phase;
    logic [6:0] cnt;
    logic       len_bad;

    assign pwrite = 1'b0;

    always_comb begin
        len_bad = prdata[7]
               || (prdata[6:0] == 7'd0)
               || ({1'b0, prdata[6:0]} > MAX8);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        psel     = 1'b0;
        penable  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_SETUP;
            end
            S_SETUP: begin
                psel     = 1'b1;
                state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // empty FIFO: drop the read and retry from IDLE
                if (pready) begin
                    state_nx = pslverr ? S_IDLE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nx = (phase == PH_PAY) ? S_EMIT : S_IDLE;
            end
            S_EMIT: begin
                if (m_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= PH_HUNT;
            cnt        <= 7'd0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_len  <= 7'h00;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_len    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!enable) begin
                        phase <= PH_HUNT;
                        cnt   <= 7'd0;
                    end
                end
                S_CAPTURE: begin
                    // prdata is only meaningful in this cycle
                    unique case (phase)
                        PH_HUNT: begin
                            if (prdata == SFD) phase <= PH_LEN;
                        end
                        PH_LEN: begin
                            if (len_bad) begin
                                err_len <= 1'b1;
                                phase   <= PH_HUNT;
                            end else begin
                                frame_len <= prdata[6:0];
                                cnt       <= 7'd0;
                                phase     <= PH_PAY;
                            end
                        end
                        PH_PAY: begin
                            m_data  <= prdata;
                            m_valid <= 1'b1;
                            m_last  <= (cnt == frame_len - 7'd1);
                        end
                        default: phase <= PH_HUNT;
                    endcase
                end
                S_EMIT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        cnt     <= cnt + 7'd1;
                        if (m_last) begin
                            frame_done <= 1'b1;
                            phase      <= PH_HUNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: bench for rx_frame_ctrl with an APB FIFO model,
// a stream monitor and a byte-stream framing reference.

module tb_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic       pready;
    logic       pslverr;
    logic [7:0] prdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [6:0] frame_len;
    logic       frame_done;
    logic       err_len;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fifo[$];
    logic [7:0] stim[$];
    logic [8:0] got[$];
    logic [8:0] exp_beats[$];
    int         nd;
    int         ne;
    int         hold_viol;
    int         exp_nd;
    int         exp_ne;
    logic [6:0] exp_flen;

    logic       pv;
    logic       pr;
    logic       pl;
    logic [7:0] pd;

    always #5 clk = ~clk;

    rx_frame_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .err_len    (err_len)
    );

    // FIFO: registered read data one cycle after the access phase, else 0
    always @(posedge clk or posedge reset) begin
        logic [7:0] b;
        if (reset) begin
            prdata  <= 8'h00;
            pslverr <= 1'b1;
        end else begin
            if (psel && penable && pready && !pslverr) begin
                b = fifo.pop_front();
                prdata <= b;
            end else begin
                prdata <= 8'h00;
            end
            pslverr <= (fifo.size() == 0);
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            if (frame_done) nd++;
            if (err_len) ne++;
            if (m_valid && psel) hold_viol++;
            if (pwrite) hold_viol++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl))
                hold_viol++;
        end
        pv = m_valid && !reset;
        pr = m_ready;
        pd = m_data;
        pl = m_last;
    end

    // framing rules applied to a plain byte list
    task automatic model();
        int mode;
        int rem;
        logic [6:0] l;
        exp_beats.delete();
        exp_nd = 0;
        exp_ne = 0;
        exp_flen = 7'd0;
        mode = 0;
        rem = 0;
        foreach (stim[i]) begin
            if (mode == 0) begin
                if (stim[i] == 8'hA7) mode = 1;
            end else if (mode == 1) begin
                l = stim[i][6:0];
                if (stim[i][7] || l == 7'd0) begin
                    exp_ne++;
                    mode = 0;
                end else begin
                    exp_flen = l;
                    rem = int'(l);
                    mode = 2;
                end
            end else begin
                rem--;
                exp_beats.push_back({(rem == 0) ? 1'b1 : 1'b0, stim[i]});
                if (rem == 0) begin
                    exp_nd++;
                    mode = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        pready = 1'b1;
        m_ready = 1'b1;
        fifo.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got.delete();
        nd = 0;
        ne = 0;
        hold_viol = 0;
    endtask

    task automatic start();
        foreach (stim[i]) fifo.push_back(stim[i]);
        enable = 1'b1;
    endtask

    task automatic drain(input int rmode, input int budget,
                         output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            m_ready = rmode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
            pready = rmode[1] ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (fifo.size() == 0 && !m_valid) quiet++;
            else quiet = 0;
            if (quiet >= 12) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        pready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        pready = 1'b1;
        m_ready = 1'b1;
        #1;
        n_chk++;
        if ({psel, penable, pwrite, m_valid, m_last,
             frame_done, err_len, m_data} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outs got %b exp 0",
                     {psel, penable, pwrite, m_valid, m_last,
                      frame_done, err_len, m_data});
        end
        n_chk++;
        if (frame_len !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_flen got %h exp 00", frame_len);
        end
    endtask

    task automatic test_empty();
        int last;
        int periods;
        int bad;
        do_reset();
        enable = 1'b1;
        last = -1;
        periods = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (psel && !penable) begin
                if (last >= 0) begin
                    periods++;
                    if (c - last != 3) bad++;
                end
                last = c;
            end
            if (m_valid) bad++;
        end
        n_chk++;
        if (periods < 10) begin
            n_fail++;
            $display("FAIL empty_polls got %0d exp >=10", periods);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL empty_period got %0d bad exp 0", bad);
        end
    endtask

    task automatic test_frame();
        bit ok;
        do_reset();
        stim = '{8'h00, 8'hA7, 8'h03, 8'h11, 8'h22, 8'h33};
        start();
        drain(0, 400, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL frame_timeout got busy exp idle");
        end
        n_chk++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL frame_beats got %0d exp 3", got.size());
        end else begin
            n_chk++;
            if (got[0] !== 9'h011 || got[1] !== 9'h022
                || got[2] !== 9'h133) begin
                n_fail++;
                $display("FAIL frame_data got %h %h %h exp 011 022 133",
                         got[0], got[1], got[2]);
            end
        end
        n_chk++;
        if (nd != 1 || ne != 0) begin
            n_fail++;
            $display("FAIL frame_pulses got %0d/%0d exp 1/0", nd, ne);
        end
        n_chk++;
        if (frame_len !== 7'd3) begin
            n_fail++;
            $display("FAIL frame_len got %0d exp 3", frame_len);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit found;
        int bad;
        do_reset();
        stim = '{8'hA7, 8'h03, 8'h11, 8'h22, 8'h33};
        start();
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (m_valid && m_data == 8'h22) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_find got none exp byte 22");
        end
        m_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!m_valid || m_data !== 8'h22 || psel) bad++;
            @(negedge clk);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold got %0d bad cycles exp 0", bad);
        end
        drain(0, 400, ok);
        n_chk++;
        if (!ok || got.size() != 3) begin
            n_fail++;
            $display("FAIL stall_beats got %0d exp 3", got.size());
        end else begin
            n_chk++;
            if (got[1] !== 9'h022 || got[2] !== 9'h133 || nd != 1) begin
                n_fail++;
                $display("FAIL stall_data got %h %h nd %0d exp 022 133 1",
                         got[1], got[2], nd);
            end
        end
        n_chk++;
        if (hold_viol != 0) begin
            n_fail++;
            $display("FAIL stall_protocol got %0d exp 0", hold_viol);
        end
    endtask

    task automatic test_err_len();
        bit ok;
        do_reset();
        stim = '{8'hA7, 8'h85, 8'hA7, 8'h01, 8'h5A};
        start();
        drain(0, 400, ok);
        n_chk++;
        if (!ok || ne != 1) begin
            n_fail++;
            $display("FAIL err_pulse got %0d exp 1", ne);
        end
        n_chk++;
        if (got.size() != 1) begin
            n_fail++;
            $display("FAIL err_beats got %0d exp 1", got.size());
        end else begin
            n_chk++;
            if (got[0] !== 9'h15A) begin
                n_fail++;
                $display("FAIL err_data got %h exp 15a", got[0]);
            end
        end
        n_chk++;
        if (nd != 1 || frame_len !== 7'd1) begin
            n_fail++;
            $display("FAIL err_done got %0d len %0d exp 1 1",
                     nd, frame_len);
        end
    endtask

    task automatic test_pready();
        bit ok;
        bit found;
        int bad;
        do_reset();
        pready = 1'b0;
        stim = '{8'hA7, 8'h01, 8'h77};
        start();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (psel && penable) begin
                found = 1'b1;
                break;
            end
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!(psel && penable)) bad++;
        end
        n_chk++;
        if (!found || bad != 0) begin
            n_fail++;
            $display("FAIL pready_hold got %0d/%0d exp 1/0", found, bad);
        end
        pready = 1'b1;
        drain(0, 400, ok);
        n_chk++;
        if (!ok || got.size() != 1 || nd != 1) begin
            n_fail++;
            $display("FAIL pready_frame got %0d beats nd %0d exp 1 1",
                     got.size(), nd);
        end else begin
            n_chk++;
            if (got[0] !== 9'h177) begin
                n_fail++;
                $display("FAIL pready_data got %h exp 177", got[0]);
            end
        end
    endtask

    task automatic test_max_len();
        bit ok;
        int bad;
        do_reset();
        stim = '{8'hA7, 8'h7F};
        for (int i = 0; i < 127; i++) stim.push_back(8'($urandom));
        model();
        start();
        drain(1, 3000, ok);
        n_chk++;
        if (!ok || got.size() != exp_beats.size()) begin
            n_fail++;
            $display("FAIL max_beats got %0d exp %0d",
                     got.size(), exp_beats.size());
        end else begin
            bad = 0;
            foreach (exp_beats[i]) if (got[i] !== exp_beats[i]) bad++;
            n_chk++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL max_data got %0d wrong exp 0", bad);
            end
        end
        n_chk++;
        if (frame_len !== 7'd127 || nd != exp_nd) begin
            n_fail++;
            $display("FAIL max_len got %0d nd %0d exp 127 %0d",
                     frame_len, nd, exp_nd);
        end
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        int r;
        logic [7:0] j;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            stim.delete();
            for (int f = 0; f < 6; f++) begin
                if ($urandom_range(0, 2) == 0) begin
                    j = 8'($urandom);
                    stim.push_back(j == 8'hA7 ? 8'h00 : j);
                end
                stim.push_back(8'hA7);
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    stim.push_back(8'h00);
                end else if (r == 1) begin
                    stim.push_back(8'h80 | 8'($urandom));
                end else begin
                    r = $urandom_range(1, 6);
                    stim.push_back(8'(r));
                    for (int k = 0; k < r; k++)
                        stim.push_back(8'($urandom));
                end
            end
            model();
            start();
            drain(3, 4000, ok);
            bad = 0;
            if (got.size() != exp_beats.size()) bad++;
            else foreach (exp_beats[i]) if (got[i] !== exp_beats[i]) bad++;
            n_chk++;
            if (!ok || bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_beats got %0d (%0d bad) exp %0d",
                         it, got.size(), bad, exp_beats.size());
            end
            n_chk++;
            if (nd != exp_nd || ne != exp_ne) begin
                n_fail++;
                $display("FAIL rand%0d_pulses got %0d/%0d exp %0d/%0d",
                         it, nd, ne, exp_nd, exp_ne);
            end
            n_chk++;
            if (frame_len !== exp_flen || hold_viol != 0) begin
                n_fail++;
                $display("FAIL rand%0d_len got %0d viol %0d exp %0d 0",
                         it, frame_len, hold_viol, exp_flen);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        do_reset();
        stim = '{8'hA7, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        m_ready = 1'b0;
        start();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_valid) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (!found || {psel, penable, m_valid, m_last, frame_done,
                       err_len, m_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL midrst_outs got %b found %0d exp 0",
                     {psel, penable, m_valid, m_last, m_data}, found);
        end
        n_chk++;
        if (frame_len !== 7'h00) begin
            n_fail++;
            $display("FAIL midrst_flen got %0d exp 0", frame_len);
        end
        fifo.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_chk++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL midrst_done got %0d exp 0", nd);
        end
        m_ready = 1'b1;
        got.delete();
        stim = '{8'hA7, 8'h02, 8'hAA, 8'hBB};
        start();
        drain(0, 400, ok);
        n_chk++;
        if (!ok || got.size() != 2 || nd != 1) begin
            n_fail++;
            $display("FAIL midrst_resume got %0d beats nd %0d exp 2 1",
                     got.size(), nd);
        end else begin
            n_chk++;
            if (got[0] !== 9'h0AA || got[1] !== 9'h1BB) begin
                n_fail++;
                $display("FAIL midrst_data got %h %h exp 0aa 1bb",
                         got[0], got[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        pready = 1'b1;
        m_ready = 1'b1;
        nd = 0;
        ne = 0;
        hold_viol = 0;
        test_reset();
        test_empty();
        test_frame();
        test_stall();
        test_err_len();
        test_pready();
        test_max_len();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
